// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared CPU/memory bus constants, command and responder-state enums
package mem_bus_pkg;
  localparam int BUS_ADDR_W = 9;
  localparam int BUS_DATA_W = 16;
  localparam logic [BUS_ADDR_W-1:0] LED_ADDR_DEF = 9'h100;
  localparam logic [BUS_ADDR_W-1:0] SW_ADDR_DEF  = 9'h140;
  typedef enum logic [1:0] {M_NONE = 2'b00, M_READ = 2'b01, M_WRITE = 2'b10} mem_cmd_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} resp_state_t;
endpackage

// File: rtl/ram_1rw.sv
// ram_1rw: single-port synchronous RAM, write enable, registered read (q holds when not reading)
// Ports: i_clk clock; i_we write enable; i_re read enable; i_addr word address;
//        i_wdata store data; o_rdata registered read data
module ram_1rw
  import mem_bus_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = BUS_DATA_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: bus target decoding CPU accesses to RAM / LED / switch I/O with wait states
// Ports: i_clk clock; i_rst_n async active-low reset; i_mem_cmd 00 none/01 read/10 write/11 illegal;
//        i_mem_addr, i_write_data access address/data; i_switches board switches;
//        o_read_data load data; o_mem_ready one-cycle completion pulse; o_leds LED register;
//        o_err one-cycle decode/command error pulse
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int                ADDR_W      = BUS_ADDR_W,
  parameter int                DATA_W      = BUS_DATA_W,
  parameter int                MEM_WORDS   = 256,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR    = LED_ADDR_DEF,
  parameter logic [ADDR_W-1:0] SW_ADDR     = SW_ADDR_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_mem_cmd,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic [7:0]        i_switches,
  output logic [DATA_W-1:0] o_read_data,
  output logic              o_mem_ready,
  output logic [7:0]        o_leds,
  output logic              o_err
);
  localparam int RAM_AW = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0] RAM_LIM = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [3:0] WAIT = 4'(WAIT_CYCLES);
  resp_state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [1:0] r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0] r_leds;
  logic r_err, r_rd_ram;
  logic [DATA_W-1:0] r_io_rd, w_ram_q;
  logic w_start, w_fire, w_rd, w_wr, w_is_ram, w_is_led, w_is_sw, w_dec_err;
  logic [1:0] w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  assign w_start = r_state == IDLE && (i_mem_cmd == M_READ || i_mem_cmd == M_WRITE);
  // With zero wait states the access happens on the sampling edge, so the live bus feeds the
  // access path in IDLE; in BUSY only the captured copies are used.
  assign w_cmd   = r_state == IDLE ? i_mem_cmd : r_cmd;
  assign w_addr  = r_state == IDLE ? i_mem_addr : r_addr;
  assign w_wdata = r_state == IDLE ? i_write_data : r_wdata;
  assign w_rd = w_fire && w_cmd == M_READ;
  assign w_wr = w_fire && w_cmd == M_WRITE;
  assign w_is_ram = {1'b0, w_addr} < RAM_LIM;
  assign w_is_led = w_addr == LED_ADDR;
  assign w_is_sw  = w_addr == SW_ADDR;
  assign w_dec_err = w_rd ? !(w_is_ram || w_is_led || w_is_sw) : w_wr && !(w_is_ram || w_is_led);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_fire = (w_start && WAIT == 4'd0) || (r_state == BUSY && r_cnt == 4'd1);
    w_next = w_fire ? DONE : w_start ? BUSY : r_state == DONE ? IDLE : r_state;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_cmd    <= M_NONE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_leds   <= '0;
      r_err    <= 1'b0;
      r_rd_ram <= 1'b0;
      r_io_rd  <= '0;
    end else begin
      r_err <= w_dec_err || (r_state == IDLE && i_mem_cmd == 2'b11);
      if (w_start) begin
        r_cnt   <= WAIT;
        r_cmd   <= i_mem_cmd;
        r_addr  <= i_mem_addr;
        r_wdata <= i_write_data;
      end else if (r_state == BUSY) r_cnt <= r_cnt - 4'd1;
      if (w_wr && w_is_led) r_leds <= w_wdata[7:0];
      // RAM reads land in the RAM's own output register; I/O reads land here. r_rd_ram picks which.
      if (w_rd) begin
        r_rd_ram <= w_is_ram;
        r_io_rd  <= w_is_sw ? DATA_W'(i_switches) : w_is_led ? DATA_W'(r_leds) : '0;
      end
    end
  end
  ram_1rw #(.DEPTH(MEM_WORDS), .DATA_W(DATA_W), .ADDR_W(RAM_AW)) u_ram (
    .i_clk  (i_clk),
    .i_we   (w_wr && w_is_ram),
    .i_re   (w_rd && w_is_ram),
    .i_addr (w_addr[RAM_AW-1:0]),
    .i_wdata(w_wdata),
    .o_rdata(w_ram_q)
  );
  assign o_read_data = r_rd_ram ? w_ram_q : r_io_rd;
  assign o_mem_ready = r_state == DONE;
  assign o_leds      = r_leds;
  assign o_err       = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table vectors, corner sequences and randomized accesses against a bus model
module tb_mem_responder;
  import mem_bus_pkg::*;
  localparam int W = 3;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [1:0] cmd = 2'b00;
  logic [8:0] addr = '0;
  logic [15:0] wd = '0, rd;
  logic [7:0] sw = '0, leds;
  logic rdy, err;
  int nvec = 0, nmis = 0;
  logic [15:0] ram_m [256];
  bit ram_ok [256];
  logic [15:0] rd_m = '0;
  bit rd_valid = 1'b1;
  logic [7:0] leds_m = '0;
  always #5 clk = ~clk;
  mem_responder #(.WAIT_CYCLES(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_cmd(cmd), .i_mem_addr(addr), .i_write_data(wd),
    .i_switches(sw), .o_read_data(rd), .o_mem_ready(rdy), .o_leds(leds), .o_err(err)
  );
  typedef struct {
    logic [1:0] c; logic [8:0] a; logic [15:0] d; logic [7:0] s;
    logic [15:0] rd; logic e; logic [7:0] l;
  } vec_t;
  vec_t tbl [13];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Bus behaviour: what one completed access should do to RAM, LEDs, read data and err
  task automatic model(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                       input logic [7:0] s, output logic e);
    e = 1'b0;
    if (c == M_WRITE) begin
      if (a < 256) begin ram_m[a] = d; ram_ok[a] = 1'b1; end
      else if (a == 9'h100) leds_m = d[7:0];
      else e = 1'b1;
    end else begin
      rd_valid = 1'b1;
      if (a < 256) begin rd_m = ram_m[a]; rd_valid = ram_ok[a]; end
      else if (a == 9'h140) rd_m = {8'h00, s};
      else if (a == 9'h100) rd_m = {8'h00, leds_m};
      else begin rd_m = 16'h0000; e = 1'b1; end
    end
  endtask
  task automatic access(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                        output logic [15:0] ard, output logic aerr, output logic [7:0] aleds);
    int n;
    cmd = c; addr = a; wd = d;
    tick;
    cmd = M_NONE; addr = 9'($urandom); wd = 16'($urandom);
    n = 0;
    while (rdy !== 1'b1 && n < 20) begin tick; n++; end
    chk("latency", n, W);
    ard = rd; aerr = err; aleds = leds;
    tick;
    chk("ready_width", rdy, 1'b0);
    chk("err_width", err, 1'b0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [15:0] ard;
    logic aerr, e_exp;
    logic [7:0] aleds;
    int p;
    tbl[0]  = '{M_WRITE, 9'h005, 16'hBEEF, 8'h00, 16'h0000, 1'b0, 8'h00};
    tbl[1]  = '{M_READ,  9'h005, 16'h0000, 8'h00, 16'hBEEF, 1'b0, 8'h00};
    tbl[2]  = '{M_WRITE, 9'h100, 16'h00A5, 8'h00, 16'hBEEF, 1'b0, 8'hA5};
    tbl[3]  = '{M_READ,  9'h100, 16'h0000, 8'h00, 16'h00A5, 1'b0, 8'hA5};
    tbl[4]  = '{M_READ,  9'h140, 16'h0000, 8'h3C, 16'h003C, 1'b0, 8'hA5};
    tbl[5]  = '{M_WRITE, 9'h140, 16'hFFFF, 8'h3C, 16'h003C, 1'b1, 8'hA5};
    tbl[6]  = '{M_READ,  9'h1FF, 16'h0000, 8'h00, 16'h0000, 1'b1, 8'hA5};
    tbl[7]  = '{M_WRITE, 9'h1FF, 16'h1111, 8'h00, 16'h0000, 1'b1, 8'hA5};
    tbl[8]  = '{M_WRITE, 9'h010, 16'h5555, 8'h00, 16'h0000, 1'b0, 8'hA5};
    tbl[9]  = '{M_READ,  9'h010, 16'h0000, 8'h00, 16'h5555, 1'b0, 8'hA5};
    tbl[10] = '{M_READ,  9'h101, 16'h0000, 8'h00, 16'h0000, 1'b1, 8'hA5};
    tbl[11] = '{M_WRITE, 9'h0FF, 16'h7777, 8'h00, 16'h0000, 1'b0, 8'hA5};
    tbl[12] = '{M_READ,  9'h0FF, 16'h0000, 8'h00, 16'h7777, 1'b0, 8'hA5};
    #2 rst_n = 1'b0;
    #1;
    chk("reset read_data", rd, 16'h0000);
    chk("reset mem_ready", rdy, 1'b0);
    chk("reset leds", leds, 8'h00);
    chk("reset err", err, 1'b0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 13; i++) begin
      sw = tbl[i].s;
      model(tbl[i].c, tbl[i].a, tbl[i].d, tbl[i].s, e_exp);
      access(tbl[i].c, tbl[i].a, tbl[i].d, ard, aerr, aleds);
      chk($sformatf("vec%0d read_data", i), ard, tbl[i].rd);
      chk($sformatf("vec%0d err", i), aerr, tbl[i].e);
      chk($sformatf("vec%0d leds", i), aleds, tbl[i].l);
    end
    cmd = 2'b11;
    tick;
    chk("illegal err", err, 1'b1);
    chk("illegal ready", rdy, 1'b0);
    cmd = M_NONE;
    tick;
    chk("illegal err width", err, 1'b0);
    tick; tick; tick;
    chk("illegal no ready", rdy, 1'b0);
    cmd = M_WRITE; addr = 9'h010; wd = 16'h1234;
    tick;
    cmd = M_NONE;
    tick;
    rst_n = 1'b0;
    #1;
    chk("busy reset read_data", rd, 16'h0000);
    chk("busy reset ready", rdy, 1'b0);
    chk("busy reset leds", leds, 8'h00);
    chk("busy reset err", err, 1'b0);
    tick;
    rst_n = 1'b1;
    leds_m = 8'h00; rd_m = 16'h0000; rd_valid = 1'b1;
    tick;
    model(M_READ, 9'h010, 16'h0000, sw, e_exp);
    access(M_READ, 9'h010, 16'h0000, ard, aerr, aleds);
    chk("abandoned write read_data", ard, rd_m);
    chk("abandoned write err", aerr, e_exp);
    cmd = M_READ; addr = 9'h005;
    p = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (rdy === 1'b1) p++;
    end
    cmd = M_NONE;
    chk("repeat pulses", p, 2);
    model(M_READ, 9'h005, 16'h0000, sw, e_exp);
    chk("repeat read_data", rd, rd_m);
    tick; tick;
    chk("repeat stops", rdy, 1'b0);
    for (int i = 0; i < 150; i++) begin
      logic [8:0] a;
      logic [1:0] c;
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0: a = 9'($urandom_range(0, 255));
        1: a = 9'h100;
        2: a = 9'h140;
        default: begin
          a = 9'($urandom_range(9'h101, 9'h1FF));
          if (a == 9'h140) a = 9'h1FF;
        end
      endcase
      c = $urandom_range(0, 1) ? M_READ : M_WRITE;
      d = 16'($urandom);
      sw = 8'($urandom);
      model(c, a, d, sw, e_exp);
      access(c, a, d, ard, aerr, aleds);
      chk($sformatf("rnd%0d err", i), aerr, e_exp);
      chk($sformatf("rnd%0d leds", i), aleds, leds_m);
      if (rd_valid) chk($sformatf("rnd%0d read_data", i), ard, rd_m);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
